// File: rtl/memdump_if.sv
// memdump_if: console read port plus dump output stream of the memory-dump controller.
//   con_addr  : registered word address to the data-memory console port
//   con_out   : console read data, valid one cycle after con_addr changes
//   out_valid : dump word available
//   out_ready : downstream accepts the word
//   out_addr  : word address of the presented word
//   out_data  : presented word
// Modports: master = controller side, slave = memory / sink side.
interface memdump_if #(
    parameter int unsigned ADDR_W = 14
);
    logic [ADDR_W-1:0] con_addr;
    logic [31:0]       con_out;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_data;

    modport master (
        output con_addr,
        input  con_out,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data
    );

    modport slave (
        input  con_addr,
        output con_out,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data
    );
endinterface

// File: rtl/memdump_ctrl.sv
// memdump_ctrl: watches the fetch-stage instruction for a halted core (one instruction
// repeated HALT_SAME times, or a NOP repeated HALT_NOPS times) and then streams data memory
// words 0..last_addr_i out over a valid/ready port, one word per ISSUE/CAPTURE/SEND round.
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   arm_i       : enables halt detection and the dump; low aborts to idle
//   inst_i      : fetch-stage instruction
//   last_addr_i : last word address to dump (inclusive), sampled when the dump starts
//   dump        : console read port and dump output stream (memdump_if.master)
//   busy_o      : dump in progress (ISSUE, CAPTURE, SEND)
//   done_o      : dump finished, waiting for arm_i to drop
module memdump_ctrl #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned HALT_SAME = 49,
    parameter int unsigned HALT_NOPS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_i,
    input  logic [31:0]       inst_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    memdump_if.master         dump,
    output logic              busy_o,
    output logic              done_o
);
    localparam int unsigned SameW = $clog2(HALT_SAME + 1);
    localparam int unsigned NopW  = $clog2(HALT_NOPS + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StCapture, StSend, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] end_addr_q;
    logic [ADDR_W-1:0] con_addr_q;
    logic              out_valid_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [31:0]       out_data_q;
    logic              busy_q;
    logic              done_q;
    logic [31:0]       last_inst_q;
    logic [SameW-1:0]  same_cnt_q;
    logic [NopW-1:0]   nop_cnt_q;

    logic is_nop;
    logic halt;

    always_comb begin
        // Compressed c.nop (low half 0x0001) or canonical addi x0,x0,0.
        is_nop = (inst_i[15:0] == 16'h0001) || (inst_i == 32'h0000_0013);
        halt   = (same_cnt_q == SameW'(HALT_SAME)) || (nop_cnt_q == NopW'(HALT_NOPS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            end_addr_q  <= '0;
            con_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            last_inst_q <= '0;
            same_cnt_q  <= '0;
            nop_cnt_q   <= '0;
        end else if (!arm_i) begin
            // Disarm aborts any dump; leaving a dump restarts halt detection from scratch.
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            if (state_q != StIdle) begin
                same_cnt_q <= '0;
                nop_cnt_q  <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (inst_i != last_inst_q) begin
                        last_inst_q <= inst_i;
                        same_cnt_q  <= '0;
                        nop_cnt_q   <= '0;
                    end else begin
                        if (same_cnt_q != SameW'(HALT_SAME)) begin
                            same_cnt_q <= same_cnt_q + 1'b1;
                        end
                        if (!is_nop) begin
                            nop_cnt_q <= '0;
                        end else if (nop_cnt_q != NopW'(HALT_NOPS)) begin
                            nop_cnt_q <= nop_cnt_q + 1'b1;
                        end
                    end
                    if (halt) begin
                        state_q    <= StIssue;
                        addr_q     <= '0;
                        end_addr_q <= last_addr_i;
                        con_addr_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                StIssue: begin
                    // con_addr_q already holds addr_q; memory answers next cycle.
                    state_q <= StCapture;
                end
                StCapture: begin
                    out_data_q  <= dump.con_out;
                    out_addr_q  <= addr_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StSend;
                end
                StSend: begin
                    if (dump.out_ready) begin
                        out_valid_q <= 1'b0;
                        // Compare before incrementing so an all-ones end never wraps.
                        if (addr_q == end_addr_q) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q     <= addr_q + 1'b1;
                            con_addr_q <= addr_q + 1'b1;
                            state_q    <= StIssue;
                        end
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dump.con_addr  = con_addr_q;
    assign dump.out_valid = out_valid_q;
    assign dump.out_addr  = out_addr_q;
    assign dump.out_data  = out_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
endmodule

// File: tb/tb_memdump_ctrl.sv
// tb_memdump_ctrl: directed bench for memdump_ctrl with a queue scoreboard on the dump stream.
module tb_memdump_ctrl;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic [31:0]   inst;
    logic [AW-1:0] last_addr;
    logic          busy;
    logic          done;

    memdump_if #(.ADDR_W(AW)) dif ();

    memdump_ctrl #(.ADDR_W(AW), .HALT_SAME(49), .HALT_NOPS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .arm_i       (arm),
        .inst_i      (inst),
        .last_addr_i (last_addr),
        .dump        (dif),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous read, data valid one cycle after the address changes.
    logic [31:0] mem [16];
    always @(posedge clk) dif.con_out <= mem[dif.con_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    bit   gap_en = 1'b0;
    int   last_hs = -1;

    // Monitor: every handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && dif.out_valid && dif.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got addr %0d data %0h want no word",
                         dif.out_addr, dif.out_data);
            end else begin
                e = exp_q.pop_front();
                check("word_addr", 32'(dif.out_addr), 32'(e.a));
                check("word_data", dif.out_data, e.d);
            end
            if (gap_en && last_hs >= 0) check("hs_gap", cyc - last_hs, 3);
            last_hs = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{a: AW'(i), d: mem[i]});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_valid"}, 32'(dif.out_valid), 0);
        check({tag, "_con_addr"}, 32'(dif.con_addr), 0);
        check({tag, "_out_addr"}, 32'(dif.out_addr), 0);
        check({tag, "_out_data"}, dif.out_data, 0);
    endtask

    initial begin
        int k;
        mem[0] = 32'd11;
        mem[1] = 32'd22;
        mem[2] = 32'd33;
        mem[3] = 32'd44;
        for (int i = 4; i < 16; i++) mem[i] = 32'hC0DE_0000 + i;

        rst = 1'b1;
        arm = 1'b0;
        inst = '0;
        last_addr = '0;
        dif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // NOP halt after 16 repeats, then dump words 0..3 back to back.
        last_addr = 4'd3;
        arm = 1'b1;
        inst = 32'h0000_0013;
        push_words(4);
        gap_en = 1'b1;
        last_hs = -1;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) begin
                k = i;
                break;
            end
        end
        check("nop_halt_edges", k, 18);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("dump4_done", 32'(done), 1);
        check("dump4_busy", 32'(busy), 0);
        check("dump4_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("done_hold", 32'(done), 1);
        gap_en = 1'b0;
        arm = 1'b0;
        @(negedge clk);
        check("disarm_done", 32'(done), 0);

        // Repeated non-NOP: a change at repeat 30 restarts the count; halt at 49 repeats.
        arm = 1'b1;
        inst = 32'h00A0_0093;
        last_addr = 4'hF;
        repeat (31) @(posedge clk);
        @(negedge clk);
        check("repeat30_no_halt", 32'(busy), 0);
        inst = 32'h00B0_0093;
        push_words(16);
        k = 0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) begin
                k = i;
                break;
            end
        end
        check("same_halt_edges", k, 51);

        // Stall address 1 for five cycles.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (dif.out_valid && dif.out_addr == 4'd1) break;
        end
        dif.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(dif.out_valid), 1);
            check("stall_addr", 32'(dif.out_addr), 1);
            check("stall_data", dif.out_data, mem[1]);
            check("stall_con_addr", 32'(dif.con_addr), 1);
        end
        dif.out_ready = 1'b1;

        // All-ones last address: 16 words then stop without wrapping.
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("full_done", 32'(done), 1);
        check("full_drained", exp_q.size(), 0);
        check("no_wrap_con_addr", 32'(dif.con_addr), 15);
        repeat (4) @(negedge clk);
        check("full_done_hold", 32'(done), 1);
        check("full_no_restart", 32'(busy), 0);
        arm = 1'b0;
        @(negedge clk);

        // Disarm during SEND of address 2.
        arm = 1'b1;
        inst = 32'h0000_0013;
        last_addr = 4'd3;
        push_words(2);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (dif.out_valid && dif.out_addr == 4'd2) break;
        end
        check("abort_pre_valid", 32'(dif.out_valid), 1);
        dif.out_ready = 1'b0;
        arm = 1'b0;
        @(posedge clk);
        #1;
        check("abort_valid", 32'(dif.out_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_drained", exp_q.size(), 0);
        dif.out_ready = 1'b1;

        // Reset pulse during CAPTURE.
        arm = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (busy) break;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_capture");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_needs_fresh_halt", 32'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        check("rst_fresh_halt", 32'(busy), 1);
        arm = 1'b0;
        repeat (3) @(negedge clk);
        check("final_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
